uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver, the receive end of the team's UART link (the counterpart of `UART_TX`). It oversamples `RX_IN` by a runtime-selectable prescale factor and majority-votes each bit. It recovers an 8-bit word framed as start (0), data LSB-first, optional parity, and stop (1), and presents it on a one-cycle `Data_Valid` strobe. Parity and framing errors are reported as pulses and suppress the strobe.

## Interface
- `DATA_WD`, default 8, data bits per frame.
- `PRESC_WD`, default 6, width of the `Prescale` input.
- `CLK` input 1: oversampling clock, `Prescale` ticks per bit.
- `RST` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line; idles high.
- `Prescale` input `PRESC_WD`: samples per bit. Legal values are 8, 16 and 32; other values are undefined.
- `parity_enable` input 1: 1 means a parity bit follows the data.
- `parity_type` input 1: 0 is even parity (bit = ^data), 1 is odd parity (bit = ~^data).
- `P_DATA` output `DATA_WD`: last good word, held until the next good word.
- `Data_Valid` output 1: one-cycle strobe; `P_DATA` is valid in that cycle.
- `parity_error` output 1: one-cycle pulse at end of frame.
- `stop_error` output 1: one-cycle pulse at end of frame.

## Operation
- Reset state: FSM is IDLE and all counters are 0. `P_DATA`=0, `Data_Valid`=0, `parity_error`=0, `stop_error`=0.
- Reset asserted mid-frame aborts the frame immediately. There is no strobe and no error pulse.
- Edge counter `edge_cnt` runs 0..`Prescale`-1 within each bit. Bit counter `bit_cnt` runs 0..`DATA_WD`-1 in the DATA state.
- Sampling:
  - Samples are taken at `edge_cnt` = P/2-1, P/2 and P/2+1, where P = `Prescale`.
  - The bit value is the majority of the three samples, decided at `edge_cnt` = P/2+1.
- States and transitions:
  - IDLE: wait for `RX_IN`=0. On detection, latch `Prescale`, `parity_enable` and `parity_type`, clear `edge_cnt`, and go to START. Mid-frame changes to these inputs are ignored.
  - START: if the voted start bit is 1, it is a glitch; return to IDLE at the vote cycle with no outputs. Otherwise go to DATA at `edge_cnt`=P-1.
  - DATA: shift the voted bit into bit position `bit_cnt` (LSB first). After bit `DATA_WD`-1 ends, go to PARITY if the latched parity enable is 1, else to STOP.
  - PARITY: compare the voted bit with the parity computed over the shifted data using the latched type. Set an internal parity-fail flag on mismatch. Always proceed to STOP.
  - STOP: if the voted bit is 0, set an internal stop-fail flag. At `edge_cnt`=P-1, return to IDLE and register the results:
    - Both flags clear: `P_DATA` is loaded and `Data_Valid`=1 for one cycle.
    - Otherwise: `P_DATA` is unchanged, `Data_Valid` stays 0, and each failing flag drives its error output for one cycle. Both errors may pulse together.
- Back-to-back frames: IDLE may detect the next start bit on the same cycle the result pulses are driven. There is no dead cycle beyond the IDLE entry.
- Input synchronization: `RX_IN` passes through a 2-flop synchronizer before sampling. All internal timing counts from the synchronized signal.

## Timing
- Frame length in `CLK` cycles: (1 + `DATA_WD` + `parity_enable` + 1) × P. That is 80 cycles at P=8 without parity and 88 with parity.
- Latency: result pulses rise 1 cycle after the STOP state's `edge_cnt`=P-1 cycle, i.e. frame length + 3 cycles after `RX_IN` falls (2 for the synchronizer, 1 for the register).
- `Data_Valid`, `parity_error` and `stop_error` are each high for exactly 1 cycle per frame. `Data_Valid` is mutually exclusive with both error outputs.
- Glitch rejection: a low pulse shorter than P/2 cycles on `RX_IN` produces no output activity.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- P=8, parity off, serial 0xA3 (line 0,1,1,0,0,0,1,0,1,1 at 8 cycles/bit) -> `Data_Valid` pulse once, `P_DATA`=8'hA3, no errors.
- P=8, even parity, 0xB4 with parity bit 0 -> `P_DATA`=8'hB4, `Data_Valid`=1. Repeat with parity bit 1 -> `parity_error` pulse, no `Data_Valid`, `P_DATA` still 8'hB4.
- P=16, odd parity, 0xD2 with parity bit 1 -> `P_DATA`=8'hD2. Next frame 0x55 sent back-to-back -> second strobe with 8'h55 exactly 176 cycles later.
- P=8, parity off, 0x3C with stop bit 0 -> `stop_error` pulse, no `Data_Valid`. A following valid 0x81 -> recovered correctly.
- P=8, `RX_IN` low for 3 cycles then high -> FSM back in IDLE, no pulses. A single flipped sample at `edge_cnt`=P/2-1 of a data bit -> the word is still received correctly.
- `RST` asserted during DATA state of 0xFF -> all outputs 0 immediately. After release, a 0x0F frame -> `P_DATA`=8'h0F.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with 3-sample majority vote, optional parity and stop check
module uart_rx #(
    parameter int DATA_WD  = 8,
    parameter int PRESC_WD = 6
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RX_IN,
    input  logic [PRESC_WD-1:0] Prescale,
    input  logic                parity_enable,
    input  logic                parity_type,
    output logic [DATA_WD-1:0]  P_DATA,
    output logic                Data_Valid,
    output logic                parity_error,
    output logic                stop_error
);

    localparam int BIT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [BIT_WD-1:0]   LAST_BIT = BIT_WD'(DATA_WD - 1);
    localparam logic [PRESC_WD-1:0] P_ONE    = PRESC_WD'(1);

    logic                rx_meta_q, rx_sync_q;
    logic [2:0]          state_q, state_d;
    logic [PRESC_WD-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_WD-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PRESC_WD-1:0] presc_q, presc_d;
    logic                par_en_q, par_en_d;
    logic                par_type_q, par_type_d;
    logic [1:0]          samp_q, samp_d;
    logic [DATA_WD-1:0]  shift_q, shift_d;
    logic                par_fail_q, par_fail_d;
    logic                stop_fail_q, stop_fail_d;
    logic [DATA_WD-1:0]  p_data_q, p_data_d;
    logic                data_valid_q, data_valid_d;
    logic                parity_error_q, parity_error_d;
    logic                stop_error_q, stop_error_d;

    logic [PRESC_WD-1:0] half;
    logic                samp_lo_hit, samp_mid_hit, vote_hit, bit_end;
    logic                vote, exp_parity, begin_frame;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        half         = presc_q >> 1;
        samp_lo_hit  = (edge_cnt_q == half - P_ONE);
        samp_mid_hit = (edge_cnt_q == half);
        vote_hit     = (edge_cnt_q == half + P_ONE);
        bit_end      = (edge_cnt_q == presc_q - P_ONE);
        // the third sample is the live synchronized line at the vote cycle
        vote         = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
        exp_parity   = par_type_q ? ~^shift_q : ^shift_q;
    end

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = bit_end ? '0 : edge_cnt_q + P_ONE;
        bit_cnt_d      = bit_cnt_q;
        presc_d        = presc_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        samp_d         = samp_q;
        shift_d        = shift_q;
        par_fail_d     = par_fail_q;
        stop_fail_d    = stop_fail_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;
        begin_frame    = 1'b0;

        if (samp_lo_hit)  samp_d[0] = rx_sync_q;
        if (samp_mid_hit) samp_d[1] = rx_sync_q;

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                if (!rx_sync_q) begin_frame = 1'b1;
            end
            S_START: begin
                if (vote_hit && vote) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (vote_hit) shift_d[bit_cnt_q] = vote;
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_WD'(1);
                    end
                end
            end
            S_PARITY: begin
                if (vote_hit && (vote != exp_parity)) par_fail_d = 1'b1;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (vote_hit && !vote) stop_fail_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    if (!par_fail_q && !stop_fail_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        parity_error_d = par_fail_q;
                        stop_error_d   = stop_fail_q;
                    end
                    // a start bit already visible here keeps back-to-back frames on the same bit grid
                    if (!rx_sync_q) begin_frame = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase

        if (begin_frame) begin
            state_d     = S_START;
            edge_cnt_d  = '0;
            bit_cnt_d   = '0;
            presc_d     = Prescale;
            par_en_d    = parity_enable;
            par_type_d  = parity_type;
            par_fail_d  = 1'b0;
            stop_fail_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= S_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            presc_q        <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            samp_q         <= '0;
            shift_q        <= '0;
            par_fail_q     <= 1'b0;
            stop_fail_q    <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            presc_q        <= presc_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            samp_q         <= samp_d;
            shift_q        <= shift_d;
            par_fail_q     <= par_fail_d;
            stop_fail_q    <= stop_fail_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign Data_Valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;

endmodule
